// File: rtl/brc_pkg.sv
// rtl/brc_pkg.sv - shared types, funct3 codes and branch decode for brc_iter
package brc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } brc_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Codes 010/011 are not branches and never report taken.
  function automatic logic br_decode(input logic [2:0] f3, input logic less,
                                     input logic equal);
    logic taken;
    taken = 1'b0;
    case (f3)
      F3_BEQ:           taken = equal;
      F3_BNE:           taken = ~equal;
      F3_BLT, F3_BLTU:  taken = less;
      F3_BGE, F3_BGEU:  taken = ~less;
      default:          taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/brc_chunk_cmp.sv
// rtl/brc_chunk_cmp.sv - combinational unsigned compare of one CHUNK-bit slice
module brc_chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/brc_iter.sv
// rtl/brc_iter.sv - iterative MSB-first branch comparator; BRC_EARLY_EXIT_EN ends BUSY at the first differing chunk
module brc_iter
  import brc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_br_un,
  input  logic [2:0]       i_funct3,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_br_less,
  output logic             o_br_equal,
  output logic             o_br_taken
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  brc_state_e                   state, state_n;
  logic [NCHUNK-1:0][CHUNK-1:0] a_q, b_q;
  logic [2:0]                   f3_q;
  logic [IDXW-1:0]              idx;
  logic                         decided, lt_q;

  logic [WIDTH-1:0] sign_flip;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             c_lt, c_eq;
  logic             accept, done;

  // Flipping both sign bits maps two's complement order onto unsigned order.
  assign sign_flip = i_br_un ? '0 : (WIDTH'(1) << (WIDTH - 1));

  assign a_chunk = a_q[idx];
  assign b_chunk = b_q[idx];

  brc_chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
    .a  (a_chunk),
    .b  (b_chunk),
    .lt (c_lt),
    .eq (c_eq)
  );

  assign o_ready = (state == IDLE) && !i_rst;
  assign accept  = i_valid && o_ready;
  assign done    = (state == DONE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (i_valid) state_n = BUSY;
      BUSY: begin
        if (idx == '0) state_n = DONE;
`ifdef BRC_EARLY_EXIT_EN
        else if (!decided && !c_eq) state_n = DONE;
`endif
      end
      DONE: if (i_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      idx     <= '0;
      decided <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_q     <= i_rs1_data ^ sign_flip;
        b_q     <= i_rs2_data ^ sign_flip;
        f3_q    <= i_funct3;
        idx     <= IDXW'(NCHUNK - 1);
        decided <= 1'b0;
        lt_q    <= 1'b0;
      end else if (state == BUSY) begin
        // The most significant differing chunk alone fixes the ordering.
        if (!decided && !c_eq) begin
          decided <= 1'b1;
          lt_q    <= c_lt;
        end
        if (idx != '0) idx <= idx - 1'b1;
      end
    end
  end

  assign o_valid    = done;
  assign o_br_less  = done & lt_q;
  assign o_br_equal = done & ~decided;
  assign o_br_taken = done & br_decode(f3_q, lt_q, ~decided);

endmodule

// File: tb/tb_brc_iter.sv
// tb/tb_brc_iter.sv - directed and randomized self-checking bench for brc_iter
module tb_brc_iter;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready_n, br_un, res_ready;
  logic [31:0] rs1, rs2;
  logic [2:0]  funct3;
  logic        out_valid, br_less, br_equal, br_taken;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  brc_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (in_valid),
    .o_ready    (in_ready_n),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_br_un    (br_un),
    .i_funct3   (funct3),
    .o_valid    (out_valid),
    .i_ready    (res_ready),
    .o_br_less  (br_less),
    .o_br_equal (br_equal),
    .o_br_taken (br_taken)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference: plain arithmetic on whole operands; latency from the first differing prefix.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic un,
                       input logic [2:0] f3, output logic less, output logic equal,
                       output logic taken, output int lat);
    equal = (a == b);
    less  = un ? (a < b) : ($signed(a) < $signed(b));
    case (f3)
      3'b000:         taken = equal;
      3'b001:         taken = !equal;
      3'b100, 3'b110: taken = less;
      3'b101, 3'b111: taken = !less;
      default:        taken = 1'b0;
    endcase
    lat = NCHUNK + 1;
`ifdef BRC_EARLY_EXIT_EN
    for (int k = NCHUNK; k >= 1; k--)
      if ((a >> (WIDTH - k * CHUNK)) != (b >> (WIDTH - k * CHUNK))) lat = k + 1;
`endif
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic un,
                      input logic [2:0] f3);
    rs1 = a; rs2 = b; br_un = un; funct3 = f3; in_valid = 1'b1;
    chk("ready_before_accept", in_ready_n, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rs1 = $urandom; rs2 = $urandom; br_un = $urandom_range(0, 1); funct3 = $urandom_range(0, 7);
    chk("ready_busy", in_ready_n, 0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_flags(input string tag, input logic less, input logic equal,
                             input logic taken);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_less"},  br_less,   less);
    chk({tag, "_equal"}, br_equal,  equal);
    chk({tag, "_taken"}, br_taken,  taken);
  endtask

  task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic un, input logic [2:0] f3, input int hold);
    logic less, equal, taken;
    int   lat_exp, lat;
    model(a, b, un, f3, less, equal, taken, lat_exp);
    res_ready = 1'b0;
    send(a, b, un, f3);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, lat_exp);
    check_flags(tag, less, equal, taken);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_ready"}, in_ready_n, 0);
      check_flags({tag, "_hold"}, less, equal, taken);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, "_drop_valid"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready_n, 1);
  endtask

  initial begin
    logic        less, equal, taken;
    int          lat_exp, lat;
    logic [31:0] a, b;

    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    rs1 = '0; rs2 = '0; br_un = 1'b0; funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready_n, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_less",  br_less, 0);
    chk("rst_equal", br_equal, 0);
    chk("rst_taken", br_taken, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready_n, 1);

    run_req("u_lt",     32'h0000_0005, 32'h0000_0009, 1'b1, 3'b110, 0);
    run_req("s_lt",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 1);
    run_req("u_gt",     32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b110, 0);
    run_req("eq_beq",   32'h1234_5678, 32'h1234_5678, 1'b1, 3'b000, 0);
    run_req("eq_bne",   32'h1234_5678, 32'h1234_5678, 1'b1, 3'b001, 0);
    run_req("early",    32'h8000_0000, 32'h7000_0000, 1'b1, 3'b110, 0);
    run_req("s_early",  32'h8000_0000, 32'h7000_0000, 1'b0, 3'b101, 0);
    run_req("f3_010",   32'h0000_0001, 32'h0000_0002, 1'b1, 3'b010, 0);

    // Backpressure: a new request waits behind DONE until after the result handshake.
    send(32'h0000_0100, 32'h0000_0200, 1'b1, 3'b111);
    model(32'h0000_0100, 32'h0000_0200, 1'b1, 3'b111, less, equal, taken, lat_exp);
    wait_valid(lat);
    chk("bp_latency", lat, lat_exp);
    rs1 = 32'hDEAD_BEEF; rs2 = 32'hDEAD_BEEF; br_un = 1'b0; funct3 = 3'b000; in_valid = 1'b1;
    for (int h = 0; h < 4; h++) begin
      check_flags("bp_hold", less, equal, taken);
      chk("bp_hold_ready", in_ready_n, 0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp_drop_valid", out_valid, 0);
    chk("bp_idle_ready", in_ready_n, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_accepted", in_ready_n, 0);
    model(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b000, less, equal, taken, lat_exp);
    wait_valid(lat);
    chk("bp_next_latency", lat, lat_exp);
    check_flags("bp_next", less, equal, taken);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Reset in the middle of BUSY aborts the request.
    send(32'h0000_0003, 32'h0000_0004, 1'b1, 3'b110);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", in_ready_n, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_less",  br_less, 0);
    chk("mid_rst_equal", br_equal, 0);
    chk("mid_rst_taken", br_taken, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_idle", in_ready_n, 1);
    begin
      int seen = 0;
      for (int c = 0; c < NCHUNK + 3; c++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("mid_rst_no_valid", seen, 0);
    end
    run_req("after_rst", 32'h0000_0003, 32'h0000_0004, 1'b1, 3'b110, 0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = a;
        2:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = a ^ 32'h8000_0000;
      endcase
      run_req("rand", a, b, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
